// File: rtl/lram_core_model_if.sv
// User and init port bundle of the LRAM core model.
// The bench drives the master side; the core takes the slave side.
interface lram_core_model_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
);
    localparam int NB = DATA_W / 8;

    logic              INIT_VALID;
    logic [DATA_W-1:0] INIT_DATA;
    logic              INIT_READY;
    logic              INIT_DONE;
    logic              CE;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;
    logic [NB-1:0]     BYTE_EN;
    logic [DATA_W-1:0] DI;
    logic              ERR_INJ;
    logic [DATA_W-1:0] DO;
    logic              DO_VALID;
    logic [NB-1:0]     PERR;
    logic              PERR_STICKY;

    modport master (
        output INIT_VALID, INIT_DATA, CE, WE, ADDR,
        output BYTE_EN, DI, ERR_INJ,
        input  INIT_READY, INIT_DONE, DO, DO_VALID,
        input  PERR, PERR_STICKY
    );

    modport slave (
        input  INIT_VALID, INIT_DATA, CE, WE, ADDR,
        input  BYTE_EN, DI, ERR_INJ,
        output INIT_READY, INIT_DONE, DO, DO_VALID,
        output PERR, PERR_STICKY
    );
endinterface

// File: rtl/lram_core_model.sv
// Cycle-accurate LRAM core: self-initialising array with
// byte-enable or per-byte parity writes and 1/2-cycle reads.
module lram_core_model #(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 16384,
    parameter int    ADDR_W       = 14,
    parameter int    OUT_REG      = 1,
    parameter string ECC_BYTE_SEL = "BYTE_EN",
    parameter string INIT_MODE    = "ZERO"
) (
    input logic             CLK,
    input logic             RSTN,
    lram_core_model_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam bit PAR = (ECC_BYTE_SEL == "PARITY");
    localparam bit STREAM = (INIT_MODE == "STREAM");
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_LOAD,
        S_RUN
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [NB-1:0]     par [DEPTH];

    logic              in_range;
    logic              ld_we, us_we, rd_en, we_any;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [NB-1:0]     wbe, wp;

    function automatic logic [NB-1:0] byte_par(
        input logic [DATA_W-1:0] d
    );
        byte_par = '0;
        for (int i = 0; i < NB; i++)
            byte_par[i] = ^d[8*i +: 8];
    endfunction

    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = (bus.ADDR <= LAST);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The counter holds at LAST so non-power-of-two depths never wrap.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ld_we    = 1'b0;
        unique case (state)
            S_INIT: state_nx = S_LOAD;
            S_LOAD: begin
                ld_we = STREAM ? bus.INIT_VALID : 1'b1;
                if (ld_we) begin
                    if (cnt == LAST) state_nx = S_RUN;
                    else             cnt_nx   = cnt + 1'b1;
                end
            end
            S_RUN: ;
            default: state_nx = S_INIT;
        endcase
    end

    assign us_we  = (state == S_RUN) & bus.CE & bus.WE & in_range;
    assign rd_en  = (state == S_RUN) & bus.CE & ~bus.WE;
    assign we_any = ld_we | us_we;

    always_comb begin
        wa  = bus.ADDR;
        wd  = bus.DI;
        wbe = PAR ? '1 : bus.BYTE_EN;
        wp  = byte_par(bus.DI);
        if (PAR && bus.ERR_INJ) wp[0] = ~wp[0];
        if (ld_we) begin
            wa  = cnt;
            wd  = STREAM ? bus.INIT_DATA : '0;
            wbe = '1;
            wp  = byte_par(wd);
        end
    end

    always_ff @(posedge CLK) begin
        if (we_any) begin
            for (int i = 0; i < NB; i++)
                if (wbe[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
            par[wa] <= wp;
        end
    end

    logic              v1, dv, sticky;
    logic [DATA_W-1:0] d1, dq;
    logic [NB-1:0]     p1, pq, perr;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            v1 <= 1'b0;
            d1 <= '0;
            p1 <= '0;
        end else begin
            v1 <= rd_en;
            if (rd_en) begin
                d1 <= in_range ? mem[bus.ADDR] : '0;
                p1 <= in_range ? par[bus.ADDR] : '0;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              v2;
            logic [DATA_W-1:0] d2;
            logic [NB-1:0]     p2;
            always_ff @(posedge CLK) begin
                if (!RSTN) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                    p2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
                        p2 <= p1;
                    end
                end
            end
            assign dv = v2;
            assign dq = d2;
            assign pq = p2;
        end else begin : g_nreg
            assign dv = v1;
            assign dq = d1;
            assign pq = p1;
        end
    endgenerate

    assign perr = (dv && PAR) ? (pq ^ byte_par(dq)) : '0;

    always_ff @(posedge CLK) begin
        if (!RSTN)      sticky <= 1'b0;
        else if (|perr) sticky <= 1'b1;
    end

    assign bus.INIT_READY  = (state == S_LOAD) & STREAM;
    assign bus.INIT_DONE   = (state == S_RUN);
    assign bus.DO          = dq;
    assign bus.DO_VALID    = dv;
    assign bus.PERR        = perr;
    assign bus.PERR_STICKY = sticky | (|perr);
endmodule

// File: tb/tb_lram_core_model.sv
// Scoreboard bench: three LRAM configurations driven from one
// stimulus thread, read responses checked by a DO_VALID monitor.
module tb_lram_core_model;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rstn [3];
    logic        iv   [3];
    logic [31:0] idat [3];
    logic        ce   [3];
    logic        we   [3];
    logic [3:0]  addr [3];
    logic [3:0]  be   [3];
    logic [31:0] di   [3];
    logic        ei   [3];
    logic        irdy [3];
    logic        idone[3];
    logic [31:0] dout [3];
    logic        dov  [3];
    logic [3:0]  perr [3];
    logic        pst  [3];

    lram_core_model_if #(.DATA_W(32), .ADDR_W(4)) if0 ();
    lram_core_model_if #(.DATA_W(32), .ADDR_W(4)) if1 ();
    lram_core_model_if #(.DATA_W(32), .ADDR_W(4)) if2 ();

    assign if0.INIT_VALID = iv[0];
    assign if0.INIT_DATA = idat[0];
    assign if0.CE = ce[0];
    assign if0.WE = we[0];
    assign if0.ADDR = addr[0];
    assign if0.BYTE_EN = be[0];
    assign if0.DI = di[0];
    assign if0.ERR_INJ = ei[0];
    assign irdy[0] = if0.INIT_READY;
    assign idone[0] = if0.INIT_DONE;
    assign dout[0] = if0.DO;
    assign dov[0] = if0.DO_VALID;
    assign perr[0] = if0.PERR;
    assign pst[0] = if0.PERR_STICKY;

    assign if1.INIT_VALID = iv[1];
    assign if1.INIT_DATA = idat[1];
    assign if1.CE = ce[1];
    assign if1.WE = we[1];
    assign if1.ADDR = addr[1];
    assign if1.BYTE_EN = be[1];
    assign if1.DI = di[1];
    assign if1.ERR_INJ = ei[1];
    assign irdy[1] = if1.INIT_READY;
    assign idone[1] = if1.INIT_DONE;
    assign dout[1] = if1.DO;
    assign dov[1] = if1.DO_VALID;
    assign perr[1] = if1.PERR;
    assign pst[1] = if1.PERR_STICKY;

    assign if2.INIT_VALID = iv[2];
    assign if2.INIT_DATA = idat[2];
    assign if2.CE = ce[2];
    assign if2.WE = we[2];
    assign if2.ADDR = addr[2];
    assign if2.BYTE_EN = be[2];
    assign if2.DI = di[2];
    assign if2.ERR_INJ = ei[2];
    assign irdy[2] = if2.INIT_READY;
    assign idone[2] = if2.INIT_DONE;
    assign dout[2] = if2.DO;
    assign dov[2] = if2.DO_VALID;
    assign perr[2] = if2.PERR;
    assign pst[2] = if2.PERR_STICKY;

    // u0: zero-fill, byte enables, latency 1
    lram_core_model #(
        .DATA_W(32), .DEPTH(16), .ADDR_W(4), .OUT_REG(0),
        .ECC_BYTE_SEL("BYTE_EN"), .INIT_MODE("ZERO")
    ) u0 (.CLK(clk), .RSTN(rstn[0]), .bus(if0));

    lram_core_model #(
        .DATA_W(32), .DEPTH(16), .ADDR_W(4), .OUT_REG(1),
        .ECC_BYTE_SEL("PARITY"), .INIT_MODE("STREAM")
    ) u1 (.CLK(clk), .RSTN(rstn[1]), .bus(if1));

    lram_core_model #(
        .DATA_W(32), .DEPTH(12), .ADDR_W(4), .OUT_REG(1),
        .ECC_BYTE_SEL("BYTE_EN"), .INIT_MODE("ZERO")
    ) u2 (.CLK(clk), .RSTN(rstn[2]), .bus(if2));

    typedef struct {
        logic [31:0] d;
        logic [3:0]  p;
        logic        s;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   lat[3] = '{1, 2, 2};
    int   nrd[3] = '{0, 0, 0};
    int   nval[3] = '{0, 0, 0};
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   got;
        for (int u = 0; u < 3; u++) begin
            if (dov[u] === 1'b1) begin
                got = 1'b0;
                nval[u]++;
                case (u)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                endcase
                checks++;
                if (!got) begin
                    errors++;
                    $display("FAIL u%0d read: DO_VALID with no read pending, cyc=%0d", u, cyc);
                end else if (dout[u] !== e.d || perr[u] !== e.p ||
                             pst[u] !== e.s || cyc != e.due) begin
                    errors++;
                    $display("FAIL u%0d read: do=%h perr=%b sticky=%b cyc=%0d want do=%h perr=%b sticky=%b cyc=%0d",
                             u, dout[u], perr[u], pst[u], cyc, e.d, e.p, e.s, e.due);
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(int u, logic [3:0] a, logic [31:0] d, logic [3:0] p, logic s);
        exp_t e;
        ce[u] = 1'b1;
        we[u] = 1'b0;
        addr[u] = a;
        e.d = d;
        e.p = p;
        e.s = s;
        e.due = cyc + lat[u];
        case (u)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        nrd[u]++;
        idle(1);
        ce[u] = 1'b0;
    endtask

    task automatic wr(int u, logic [3:0] a, logic [31:0] d, logic [3:0] b, logic inj);
        ce[u] = 1'b1;
        we[u] = 1'b1;
        addr[u] = a;
        di[u] = d;
        be[u] = b;
        ei[u] = inj;
        idle(1);
        ce[u] = 1'b0;
        we[u] = 1'b0;
        ei[u] = 1'b0;
    endtask

    // Every third cycle drops INIT_VALID when gap is set.
    task automatic stream(int u, logic [31:0] base, int n, bit gap);
        int acc = 0;
        int k = 0;
        while (acc < n && k < 200) begin
            iv[u] = gap ? (k % 3 != 2) : 1'b1;
            idat[u] = base + acc;
            if (iv[u] && irdy[u] === 1'b1) acc++;
            idle(1);
            k++;
        end
        iv[u] = 1'b0;
        chk($sformatf("u%0d words accepted", u), acc, n);
    endtask

    int n;

    initial begin
        for (int u = 0; u < 3; u++) begin
            rstn[u] = 1'b0;
            iv[u] = 1'b0;
            idat[u] = '0;
            ce[u] = 1'b0;
            we[u] = 1'b0;
            addr[u] = '0;
            be[u] = '0;
            di[u] = '0;
            ei[u] = 1'b0;
        end
        idle(3);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d reset DO", u), dout[u], 32'h0);
            chk($sformatf("u%0d reset flags", u),
                {idone[u], irdy[u], dov[u], pst[u], perr[u]}, 32'h0);
        end

        // u0: 1 INIT + 16 LOAD cycles, done seen in cycle 18
        rstn[0] = 1'b1;
        n = 1;
        while (idone[0] !== 1'b1 && n < 100) begin
            idle(1);
            n++;
        end
        chk("u0 done cycle", n, 18);
        rd(0, 4'd5, 32'h0, 4'h0, 1'b0);
        wr(0, 4'd3, 32'h11223344, 4'hF, 1'b0);
        wr(0, 4'd3, 32'hAABBCCDD, 4'b0101, 1'b0);
        rd(0, 4'd3, 32'h11BB33DD, 4'h0, 1'b0);
        wr(0, 4'd4, 32'h000000FF, 4'hF, 1'b1);
        rd(0, 4'd4, 32'h000000FF, 4'h0, 1'b0);
        rd(0, 4'd3, 32'h11BB33DD, 4'h0, 1'b0);
        wr(0, 4'd6, 32'h5A5A0001, 4'hF, 1'b0);
        rd(0, 4'd6, 32'h5A5A0001, 4'h0, 1'b0);
        wr(0, 4'd7, 32'h77777777, 4'hF, 1'b0);
        idle(3);
        chk("u0 DO hold", dout[0], 32'h5A5A0001);
        chk("u0 idle valid", dov[0], 1'b0);

        // u1: streamed init, parity, reset mid-load
        rstn[1] = 1'b1;
        stream(1, 32'h3000, 16, 1'b0);
        chk("u1 ready after load", irdy[1], 1'b0);
        chk("u1 done after load", idone[1], 1'b1);
        wr(1, 4'd5, 32'hCAFEBABE, 4'h0, 1'b0);
        rd(1, 4'd5, 32'hCAFEBABE, 4'h0, 1'b0);
        rd(1, 4'd7, 32'h00003007, 4'h0, 1'b0);
        wr(1, 4'd2, 32'h000000FF, 4'hF, 1'b1);
        rd(1, 4'd2, 32'h000000FF, 4'b0001, 1'b1);
        wr(1, 4'd2, 32'h000000FF, 4'hF, 1'b0);
        rd(1, 4'd2, 32'h000000FF, 4'h0, 1'b1);
        idle(4);
        chk("u1 sticky held", pst[1], 1'b1);
        rstn[1] = 1'b0;
        idle(1);
        rstn[1] = 1'b1;
        chk("u1 sticky cleared", pst[1], 1'b0);
        chk("u1 reset DO", dout[1], 32'h0);
        stream(1, 32'h2000, 7, 1'b0);
        iv[1] = 1'b1;
        idat[1] = 32'h2007;
        rstn[1] = 1'b0;
        idle(1);
        rstn[1] = 1'b1;
        iv[1] = 1'b0;
        chk("u1 mid-load reset flags",
            {idone[1], irdy[1], pst[1]}, 32'h0);
        stream(1, 32'h1000, 16, 1'b1);
        chk("u1 ready after word 15", irdy[1], 1'b0);
        chk("u1 done after word 15", idone[1], 1'b1);
        rd(1, 4'd0, 32'h00001000, 4'h0, 1'b0);
        rd(1, 4'd9, 32'h00001009, 4'h0, 1'b0);
        rd(1, 4'd15, 32'h0000100F, 4'h0, 1'b0);

        // u2: DEPTH 12, accesses during LOAD must be ignored
        rstn[2] = 1'b1;
        n = 1;
        while (idone[2] !== 1'b1 && n < 100) begin
            if (n == 4) begin
                ce[2] = 1'b1;
                we[2] = 1'b0;
                addr[2] = 4'd1;
            end
            if (n == 9) begin
                ce[2] = 1'b1;
                we[2] = 1'b1;
                addr[2] = 4'd0;
                di[2] = 32'hDEADBEEF;
                be[2] = 4'hF;
            end
            idle(1);
            ce[2] = 1'b0;
            we[2] = 1'b0;
            n++;
        end
        chk("u2 done cycle", n, 14);
        rd(2, 4'd14, 32'h0, 4'h0, 1'b0);
        rd(2, 4'd0, 32'h0, 4'h0, 1'b0);
        wr(2, 4'd2, 32'h12345678, 4'hF, 1'b0);
        wr(2, 4'd14, 32'hFFFFFFFF, 4'hF, 1'b0);
        rd(2, 4'd2, 32'h12345678, 4'h0, 1'b0);
        wr(2, 4'd3, 32'h11223344, 4'hF, 1'b0);
        wr(2, 4'd3, 32'hAABBCCDD, 4'b0101, 1'b0);
        rd(2, 4'd3, 32'h11BB33DD, 4'h0, 1'b0);
        rd(2, 4'd11, 32'h0, 4'h0, 1'b0);
        idle(6);

        for (int u = 0; u < 3; u++)
            chk($sformatf("u%0d DO_VALID count", u), nval[u], nrd[u]);
        chk("pending reads", q0.size() + q1.size() + q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lram_core_model.md
Name: lram_core_model

Overview:
- Parametrised cycle-accurate model of the LIFCL large-RAM (LRAM) core. It generalises the fixed LRAM_CORE site to configurable width and depth, a byte-enable or parity mode, and an optional output register.
- Array initialisation is sequenced by an in-block FSM after reset: either zero-fill or a streamed INITVAL load.
- Used as the reference model against which fuzzed LRAM init/mode bitstreams are checked in simulation.

Parameters:
DATA_W, 32, data word width; multiple of 8, 8..64
DEPTH, 16384, number of words; 2..2^ADDR_W
ADDR_W, 14, address width
OUT_REG, 1, 0 = read latency 1, 1 = read latency 2
ECC_BYTE_SEL, "BYTE_EN", "BYTE_EN" = byte-enable writes; "PARITY" = full-word writes with per-byte even parity
INIT_MODE, "ZERO", "ZERO" = clear array after reset; "STREAM" = load DEPTH words from INIT port

Ports:
CLK  in  1  clock, all logic on rising edge
RSTN  in  1  synchronous active-low reset
INIT_VALID  in  1  init word valid (STREAM mode)
INIT_DATA  in  DATA_W  init word
INIT_READY  out  1  block accepts init word
INIT_DONE  out  1  array initialised; user port live
CE  in  1  access enable
WE  in  1  1 = write, 0 = read (qualified by CE)
ADDR  in  ADDR_W  word address
BYTE_EN  in  DATA_W/8  byte write enables (BYTE_EN mode only)
DI  in  DATA_W  write data
ERR_INJ  in  1  on a write, store byte-0 parity inverted (PARITY mode)
DO  out  DATA_W  read data
DO_VALID  out  1  DO carries new read data this cycle
PERR  out  DATA_W/8  per-byte parity error, aligned with DO_VALID
PERR_STICKY  out  1  OR of all PERR since reset

Behaviour:
- Reset (RSTN=0 at an edge):
  - All outputs to 0; FSM to INIT; address counter to 0.
  - Read pipeline flushed. Array contents untouched by reset itself.
- FSM states INIT -> LOAD -> RUN:
  - INIT: one cycle, then LOAD.
  - LOAD, ZERO mode: writes 0 (and zero parity) to counter address every cycle. INIT_READY=0.
  - LOAD, STREAM mode: INIT_READY=1. Each cycle with INIT_VALID&INIT_READY writes INIT_DATA (parity computed) at the counter address and increments the counter. INIT_VALID=0 stalls.
  - LOAD exits after the write to address DEPTH-1. Next state RUN; INIT_READY drops the same edge. INIT_DONE=1 from the first RUN cycle.
  - RUN: terminal until reset. RSTN low mid-LOAD restarts the load from address 0.
- User port accesses are honoured only in RUN. CE in INIT/LOAD is ignored: no write, no DO_VALID.
- Write (CE&WE):
  - BYTE_EN mode: byte i updated iff BYTE_EN[i].
  - PARITY mode: whole word written, BYTE_EN ignored. Parity bit p[i] = XOR of byte i; p[0] inverted if ERR_INJ.
  - ERR_INJ is ignored in BYTE_EN mode.
  - Writes do not produce DO_VALID; DO holds its last value.
- Read (CE&~WE):
  - DO/DO_VALID/PERR appear 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
  - Back-to-back reads pipeline at 1 per cycle.
  - DO_VALID is a 1-cycle pulse per read. DO holds its value when DO_VALID=0.
- Parity check:
  - PERR[i] = stored p[i] XOR recomputed XOR of byte i, valid only with DO_VALID; otherwise 0.
  - PERR is always 0 in BYTE_EN mode.
  - PERR_STICKY sets on any PERR bit and clears only on reset.
- Read of an address written in the immediately preceding cycle returns the new data (write completes at the edge).
- Out-of-range ADDR (>= DEPTH): write ignored; read returns DO=0, PERR=0, DO_VALID=1.
- DEPTH not a power of two: the counter stops at DEPTH-1 and never wraps.

Test Plan:
- ZERO mode, DEPTH=16, OUT_REG=0: release reset -> INIT_DONE rises exactly 18 cycles after RSTN=1 (1 INIT + 16 LOAD + 1). Read addr 5 -> DO=0, DO_VALID one cycle after CE.
- STREAM mode, DEPTH=16: feed words 0x1000+n with INIT_VALID deasserted every third cycle -> INIT_READY drops after word 15. Read addr 9 -> 0x00001009.
- BYTE_EN mode: write 0xAABBCCDD to addr 3 with BYTE_EN=4'b0101 over prior 0x11223344 -> read returns 0x11BB33DD. With OUT_REG=1, DO_VALID arrives 2 cycles after CE.
- PARITY mode: write 0x000000FF with ERR_INJ=1 to addr 2, read addr 2 -> PERR=4'b0001, PERR_STICKY=1. Rewrite without ERR_INJ, read -> PERR=0, sticky stays 1.
- Assert RSTN low for 1 cycle mid-STREAM at word 7 -> INIT_DONE=0, counter restarts at 0. Next accepted word lands at addr 0; PERR_STICKY cleared.
- DEPTH=12, ADDR_W=4: CE in LOAD gives no DO_VALID. In RUN, read addr 14 -> DO=0, DO_VALID=1. Write addr 14 then read addr 2 -> addr 2 unchanged.
